rv_dmem_responder: RTL and testbench
====================================

Name: rv_dmem_responder

Overview:
Data-memory responder that sits at the far end of the memory stage's request interface. It accepts byte-enabled read/write requests carrying ALU address, lane-replicated write data, byte select and funct3. It runs them through a parameterised wait-state FSM against an internal word-wide RAM and returns aligned, sign/zero-extended load data. A combinational stall holds the pipeline until the access completes.

Parameters:
ADDR_WIDTH, 10, word-address bits; RAM depth = 2**ADDR_WIDTH 32-bit words
WAIT_CYCLES, 1, extra wait states per access (0..15)

Ports:
i_clk  input  1  clock, rising edge
i_reset_n  input  1  asynchronous active-low reset
i_addr  input  32  byte address (memory-stage ALU result)
i_mem_read  input  1  load request
i_mem_write  input  1  store request
i_mem_sel  input  4  byte lane enables for stores
i_wdata  input  32  store data, already replicated across lanes
i_funct3  input  3  load/store size and signedness
o_stall  output  1  pipeline hold; request inputs must stay stable while high
o_ack  output  1  one-cycle completion pulse
o_rdata  output  32  extended load data, valid only with o_ack on a load
o_misaligned  output  1  pulses with o_ack when the request was misaligned

Behaviour:
- Reset values: o_stall=0, o_ack=0, o_rdata=0, o_misaligned=0, FSM=IDLE, wait counter=0. RAM contents are not reset.
- Request present: req = i_mem_read | i_mem_write.
- o_stall = (IDLE & req) | BUSY. It is combinational, so the request is stalled in the same cycle it first appears.
- IDLE: on req, latch addr, sel, wdata, funct3, and op (write wins if read and write are both high). Load cnt=WAIT_CYCLES, compute the misaligned flag, go to BUSY.
- BUSY: if cnt!=0, decrement. If cnt==0, perform the access and go to RESP.
  - Write: update only the lanes set in the latched sel.
  - Read: capture the full word.
- RESP: o_ack=1, o_stall=0, o_rdata/o_misaligned registered and valid. Inputs are ignored this cycle because upstream advances at the end of it. Next state is IDLE.
- Latency: o_ack rises WAIT_CYCLES+2 cycles after the first request cycle. Back-to-back requests give a minimum of one IDLE cycle between accesses.
- Word index = addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses alias.
- Misaligned definition: halfword (funct3[1:0]=01) with addr[0]=1, or word (funct3[1:0]=1x) with addr[1:0]!=0.
- Misaligned handling: the FSM still walks all states, but the write is suppressed, o_rdata=0 and o_misaligned=1 with o_ack.
- Load extraction by latched funct3 (o_rdata on a store ack = 0):
  - 000 LB: byte addr[1:0], sign-extended
  - 100 LBU: byte addr[1:0], zero-extended
  - 001 LH: half addr[1], sign-extended
  - 101 LHU: half addr[1], zero-extended
  - 010, 011, 110, 111: full word
- Outside RESP, o_ack and o_misaligned are 0. o_rdata holds its last value.
- Async reset mid-operation: return to IDLE immediately. A write still in BUSY with cnt!=0 is dropped; a write committed on an earlier edge stays. No ack is issued for the aborted request.
- Request deasserted while stalled is a protocol violation. The FSM completes the latched request regardless.

Decomposition:
- Shared package rv_pkg:
  - load/store funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - responder state enum (IDLE, BUSY, RESP)
  - WAIT counter width constant (4)
- Sub-module rv_load_extend: combinational extract/extend of a 32-bit word by addr[1:0] and funct3. It is reused later by writeback.

Test Plan:
1. Reset release, no request, WAIT=1 -> o_stall=0, o_ack=0, o_rdata=0 for 10 cycles.
2. SW addr 0x10 wdata 0xDEADBEEF sel 1111, then LW 0x10 -> ack at cycle 3 of each request; o_rdata=0xDEADBEEF; o_stall high cycles 0–2 and low in the ack cycle.
3. After test 2, SB addr 0x11 wdata 0x5A5A5A5A sel 0010, then:
   - LB 0x11 -> 0x0000005A
   - LW 0x10 -> 0xDEAD5AEF
   - LB 0x13 -> 0xFFFFFFDE
   - LBU 0x13 -> 0x000000DE
   - LH 0x12 -> 0xFFFFDEAD
   - LHU 0x12 -> 0x0000DEAD
4. SW addr 0x12 wdata 0x11111111 -> o_ack with o_misaligned=1; subsequent LW 0x10 still returns 0xDEAD5AEF.
5. WAIT_CYCLES=0 and =3 builds -> ack 2 and 5 cycles after the request respectively; back-to-back loads produce one IDLE gap.
6. Assert i_reset_n low while a SW to 0x20 is in BUSY with cnt=2 -> outputs zero immediately, no ack; after release, LW 0x20 returns the pre-existing content.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared load/store definitions for the data-memory path: funct3 encodings,
// responder FSM states and the misalignment rule.
package rv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } resp_state_t;

  // Halfwords need an even address, words (funct3[1]=1) need a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [1:0] off, input logic [2:0] funct3);
    logic mis;
    case (funct3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/rv_load_extend.sv
// Extracts a byte/halfword/word from a 32-bit memory word and sign/zero-extends
// it according to the load funct3.
module rv_load_extend
  import rv_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    shifted = word >> {off, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_v[7]}}, byte_v};
      F3_BU:   data = {24'h0, byte_v};
      F3_H:    data = {{16{half_v[15]}}, half_v};
      F3_HU:   data = {16'h0, half_v};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/rv_dmem_responder.sv
// Word-wide data RAM behind a wait-state FSM; stalls the memory stage until the
// access completes and returns aligned, extended load data with a one-cycle ack.
module rv_dmem_responder
  import rv_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_addr,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [3:0]  i_mem_sel,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_funct3,
  output logic        o_stall,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  resp_state_t           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [3:0]            sel_q;
  logic [31:0]           wdata_q;
  logic [2:0]            f3_q;
  logic                  write_q;
  logic                  mis_q;
  logic [31:0]           rdata_q;
  logic [31:0]           mem [DEPTH];
  logic [31:0]           ext_data;
  logic                  req;
  logic                  access;
  logic                  unused_addr;

  assign req         = i_mem_read | i_mem_write;
  assign access      = (state_q == BUSY) && (cnt_q == '0);
  assign unused_addr = ^i_addr[31:ADDR_WIDTH+2];

  // Handshake: o_stall is high from the first request cycle until the ack
  // cycle; upstream keeps the request stable while stalled and advances at the
  // end of the single-cycle o_ack, which is the only cycle o_rdata is valid.
  assign o_stall      = i_reset_n & (((state_q == IDLE) & req) | (state_q == BUSY));
  assign o_ack        = (state_q == RESP);
  assign o_misaligned = (state_q == RESP) & mis_q;
  assign o_rdata      = rdata_q;

  rv_load_extend u_extend (
    .word   (mem[addr_q[ADDR_WIDTH+1:2]]),
    .off    (addr_q[1:0]),
    .funct3 (f3_q),
    .data   (ext_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = BUSY;
      BUSY:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      write_q <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req) begin
            addr_q  <= i_addr[ADDR_WIDTH+1:0];
            sel_q   <= i_mem_sel;
            wdata_q <= i_wdata;
            f3_q    <= i_funct3;
            write_q <= i_mem_write;
            mis_q   <= is_misaligned(i_addr[1:0], i_funct3);
            cnt_q   <= CNT_W'(WAIT_CYCLES);
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            // Stores and misaligned accesses report zero data.
            rdata_q <= (!write_q && !mis_q) ? ext_data : 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM is deliberately not reset; an async reset forces IDLE so no write fires.
  always_ff @(posedge i_clk) begin
    if (access && write_q && !mis_q) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_q[b]) mem[addr_q[ADDR_WIDTH+1:2]][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_rv_dmem_responder.sv
// Directed bench for rv_dmem_responder: scoreboarded main instance (WAIT=1)
// plus WAIT=0/WAIT=3 instances for latency, back-to-back and reset-abort cases.
module tb_rv_dmem_responder;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam int MAIN_W = 1;
  localparam int XW [2] = '{0, 3};

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared request bus
  logic [31:0] addr = '0;
  logic [3:0]  sel = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  f3 = '0;

  logic        m_rd = 1'b0, m_wr = 1'b0;
  logic        m_stall, m_ack, m_mis;
  logic [31:0] m_rdata;

  logic        x_rd [2];
  logic        x_wr [2];
  logic        x_stall [2];
  logic        x_ack [2];
  logic        x_mis [2];
  logic [31:0] x_rdata [2];

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];
  logic        exp_mis_q[$];

  rv_dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(MAIN_W)) u_dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_addr(addr), .i_mem_read(m_rd),
    .i_mem_write(m_wr), .i_mem_sel(sel), .i_wdata(wdata), .i_funct3(f3),
    .o_stall(m_stall), .o_ack(m_ack), .o_rdata(m_rdata), .o_misaligned(m_mis)
  );

  for (genvar g = 0; g < 2; g++) begin : g_x
    rv_dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(XW[g])) u_x (
      .i_clk(clk), .i_reset_n(rst_n), .i_addr(addr), .i_mem_read(x_rd[g]),
      .i_mem_write(x_wr[g]), .i_mem_sel(sel), .i_wdata(wdata), .i_funct3(f3),
      .o_stall(x_stall[g]), .o_ack(x_ack[g]), .o_rdata(x_rdata[g]), .o_misaligned(x_mis[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor for the main instance
  always @(negedge clk) begin
    if (rst_n && m_ack) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        chk("rdata", m_rdata, exp_q.pop_front());
        chk("misaligned", {31'b0, m_mis}, {31'b0, exp_mis_q.pop_front()});
      end
    end
  end

  // driver: issue one request on the main instance, checking stall and latency
  task automatic do_req(input logic wr, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] wd, input logic [2:0] f, input logic [31:0] exp_rd,
                        input logic exp_mis);
    bit done = 0;
    exp_q.push_back(exp_rd);
    exp_mis_q.push_back(exp_mis);
    @(posedge clk); #1;
    addr = a; sel = s; wdata = wd; f3 = f; m_rd = !wr; m_wr = wr;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (m_ack) begin
        done = 1;
        chk("ack_latency", n, MAIN_W + 2);
        chk("stall_in_ack", {31'b0, m_stall}, 32'd0);
      end else begin
        chk("stall_pending", {31'b0, m_stall}, 32'd1);
      end
    end
    if (!done) chk("ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    m_rd = 1'b0; m_wr = 1'b0;
  endtask

  task automatic x_req(input int k, input logic wr, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] wd, input logic [2:0] f, output int lat,
                       output logic [31:0] rd);
    lat = -1;
    rd = '0;
    @(posedge clk); #1;
    addr = a; sel = s; wdata = wd; f3 = f; x_rd[k] = !wr; x_wr[k] = wr;
    for (int n = 0; n < 30 && lat < 0; n++) begin
      @(negedge clk);
      if (x_ack[k]) begin
        lat = n;
        rd = x_rdata[k];
      end
    end
    @(posedge clk); #1;
    x_rd[k] = 1'b0; x_wr[k] = 1'b0;
  endtask

  task automatic x_b2b(input int k, output int first, output int second);
    first = -1;
    second = -1;
    @(posedge clk); #1;
    addr = 32'h10; sel = 4'hF; f3 = LW; x_rd[k] = 1'b1; x_wr[k] = 1'b0;
    for (int n = 0; n < 40 && second < 0; n++) begin
      @(negedge clk);
      if (x_ack[k]) begin
        if (first < 0) first = n;
        else second = n;
      end
    end
    @(posedge clk); #1;
    x_rd[k] = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] wd;
    logic [2:0]  f;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV] = '{
    '{1'b1, 32'h10,   4'hF, 32'hDEADBEEF, LW,  32'h0,        1'b0},
    '{1'b0, 32'h10,   4'hF, 32'h0,        LW,  32'hDEADBEEF, 1'b0},
    '{1'b1, 32'h11,   4'h2, 32'h5A5A5A5A, LB,  32'h0,        1'b0},
    '{1'b0, 32'h11,   4'hF, 32'h0,        LB,  32'h0000005A, 1'b0},
    '{1'b0, 32'h10,   4'hF, 32'h0,        LW,  32'hDEAD5AEF, 1'b0},
    '{1'b0, 32'h13,   4'hF, 32'h0,        LB,  32'hFFFFFFDE, 1'b0},
    '{1'b0, 32'h13,   4'hF, 32'h0,        LBU, 32'h000000DE, 1'b0},
    '{1'b0, 32'h12,   4'hF, 32'h0,        LH,  32'hFFFFDEAD, 1'b0},
    '{1'b0, 32'h12,   4'hF, 32'h0,        LHU, 32'h0000DEAD, 1'b0},
    '{1'b1, 32'h12,   4'hF, 32'h11111111, LW,  32'h0,        1'b1},
    '{1'b0, 32'h10,   4'hF, 32'h0,        LW,  32'hDEAD5AEF, 1'b0},
    '{1'b0, 32'h13,   4'hF, 32'h0,        LH,  32'h0,        1'b1},
    '{1'b0, 32'h11,   4'hF, 32'h0,        LW,  32'h0,        1'b1},
    '{1'b0, 32'h1010, 4'hF, 32'h0,        LW,  32'hDEAD5AEF, 1'b0},
    '{1'b1, 32'h12,   4'hC, 32'hBEEFBEEF, LH,  32'h0,        1'b0},
    '{1'b0, 32'h12,   4'hF, 32'h0,        LHU, 32'h0000BEEF, 1'b0},
    '{1'b0, 32'h10,   4'hF, 32'h0,        LW,  32'hBEEF5AEF, 1'b0}
  };

  initial begin
    int lat, first, second;
    logic [31:0] rd;
    for (int k = 0; k < 2; k++) begin
      x_rd[k] = 1'b0;
      x_wr[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_stall", {31'b0, m_stall}, 32'd0);
      chk("idle_ack", {31'b0, m_ack}, 32'd0);
      chk("idle_rdata", m_rdata, 32'd0);
    end

    for (int i = 0; i < NV; i++)
      do_req(vecs[i].wr, vecs[i].a, vecs[i].s, vecs[i].wd, vecs[i].f, vecs[i].exp_rd, vecs[i].exp_mis);

    // latency and back-to-back spacing on WAIT=0 and WAIT=3 builds
    for (int k = 0; k < 2; k++) begin
      x_req(k, 1'b1, 32'h10, 4'hF, 32'h0BADF00D, LW, lat, rd);
      chk("x_store_latency", lat, XW[k] + 2);
      x_req(k, 1'b0, 32'h10, 4'hF, 32'h0, LW, lat, rd);
      chk("x_load_latency", lat, XW[k] + 2);
      chk("x_load_data", rd, 32'h0BADF00D);
      x_b2b(k, first, second);
      chk("b2b_first", first, XW[k] + 2);
      chk("b2b_spacing", second - first, XW[k] + 3);
    end

    // reset while a store sits in BUSY with cnt=2 on the WAIT=3 build
    x_req(1, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, LW, lat, rd);
    chk("pre_store_latency", lat, 5);
    @(posedge clk); #1;
    addr = 32'h20; sel = 4'hF; wdata = 32'h12345678; f3 = LW; x_wr[1] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_stall", {31'b0, x_stall[1]}, 32'd0);
    chk("rst_ack", {31'b0, x_ack[1]}, 32'd0);
    chk("rst_rdata", x_rdata[1], 32'd0);
    chk("rst_main_rdata", m_rdata, 32'd0);
    x_wr[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_ack_after_abort", {31'b0, x_ack[1]}, 32'd0);
    end
    x_req(1, 1'b0, 32'h20, 4'hF, 32'h0, LW, lat, rd);
    chk("post_rst_latency", lat, 5);
    chk("post_rst_data", rd, 32'hCAFEF00D);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
